// File: rtl/prog_clock_divider.sv
// prog_clock_divider: N_CH glitch-free programmable clock dividers with a shared valid/ready divisor load port.
// A new divisor is held in a shadow register and only takes over at a period boundary or while disabled.
module prog_clock_divider #(
  parameter int N_CH = 4,
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             _RST,
  input  logic [N_CH-1:0]  EN,
  input  logic             LOAD_VALID,
  input  logic [CH_W-1:0]  LOAD_CH,
  input  logic [CNT_W-1:0] LOAD_DIV,
  output logic             LOAD_READY,
  output logic             LOAD_ERR,
  output logic [N_CH-1:0]  DIV_CLK,
  output logic [N_CH-1:0]  TICK
);
  localparam int PW = 1 << CH_W;
  logic [N_CH-1:0] pend;
  logic [PW-1:0] pend_x;
  logic in_range, legal, take;
  // out-of-range channels read as never pending so illegal requests complete and report an error
  assign pend_x = PW'(pend);
  assign in_range = {1'b0, LOAD_CH} < (CH_W + 1)'(N_CH);
  assign legal = in_range && LOAD_DIV >= CNT_W'(2);
  assign LOAD_READY = _RST && !pend_x[LOAD_CH];
  assign take = LOAD_VALID && LOAD_READY;
  always_ff @(posedge CLK or negedge _RST)
    if (!_RST) LOAD_ERR <= 1'b0;
    else LOAD_ERR <= take && !legal;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, per, shadow;
    logic dc, tk, pd, wrap, apply, acc;
    assign wrap = cnt == per - 1'b1;
    assign apply = pd && (wrap || !EN[i]);
    assign acc = take && legal && LOAD_CH == CH_W'(i);
    assign DIV_CLK[i] = dc;
    assign TICK[i] = tk;
    assign pend[i] = pd;
    always_ff @(posedge CLK or negedge _RST)
      if (!_RST) begin
        cnt <= '0;
        per <= CNT_W'(DEFAULT_DIV);
        shadow <= CNT_W'(DEFAULT_DIV);
        pd <= 1'b0;
        dc <= 1'b0;
        tk <= 1'b0;
      end else begin
        dc <= EN[i] && cnt < (per >> 1);
        tk <= EN[i] && wrap;
        cnt <= (!EN[i] || wrap) ? '0 : cnt + 1'b1;
        if (apply) per <= shadow;
        if (acc) shadow <= LOAD_DIV;
        pd <= acc || (pd && !apply);
      end
  end
endmodule
